// File: rtl/laser500_mem_arbiter.sv
// rtl/laser500_mem_arbiter.sv - fixed-priority SDRAM byte-port arbiter (dio > video > cpu)
// Optional macro ARB_FAIRNESS_EN: a waiting CPU beats video after MAX_LOSS consecutive video wins.
module laser500_mem_arbiter #(
    parameter int ADDR_W   = 25,
    parameter int MAX_LOSS = 4
) (
    input  logic              F14M,
    input  logic              RESET_n,
    input  logic              dio_req,
    input  logic [ADDR_W-1:0] dio_addr,
    input  logic [7:0]        dio_data,
    output logic              dio_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [7:0]        vid_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_wait_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic              mem_ack,
    input  logic [7:0]        mem_dout
);
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
    typedef enum logic [1:0] {OWN_DIO, OWN_VID, OWN_CPU} owner_t;

    // The loss counter is 3 bits wide, so only 1..7 are meaningful limits.
    if (MAX_LOSS < 1 || MAX_LOSS > 7) begin : g_max_loss_out_of_range
    end

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_din_q, mem_din_d;
    logic                dio_ack_q, dio_ack_d;
    logic                vid_ack_q, vid_ack_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic [7:0]          vid_data_q, vid_data_d;
    logic [7:0]          cpu_rdata_q, cpu_rdata_d;
    logic                cpu_first;

`ifdef ARB_FAIRNESS_EN
    logic [2:0]          loss_q, loss_d;
    assign cpu_first = cpu_req && (loss_q == 3'(MAX_LOSS));
`else
    assign cpu_first = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        dio_ack_d   = 1'b0;
        vid_ack_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        vid_data_d  = vid_data_q;
        cpu_rdata_d = cpu_rdata_q;
`ifdef ARB_FAIRNESS_EN
        loss_d      = loss_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (dio_req) begin
                    owner_d    = OWN_DIO;
                    mem_we_d   = 1'b1;
                    mem_addr_d = dio_addr;
                    mem_din_d  = dio_data;
                    mem_req_d  = 1'b1;
                    state_d    = ST_BUSY;
                end else if (vid_req && !cpu_first) begin
                    owner_d    = OWN_VID;
                    mem_we_d   = 1'b0;
                    mem_addr_d = vid_addr;
                    mem_req_d  = 1'b1;
                    state_d    = ST_BUSY;
`ifdef ARB_FAIRNESS_EN
                    if (cpu_req && loss_q != 3'd7) begin
                        loss_d = loss_q + 3'd1;
                    end
`endif
                end else if (cpu_req) begin
                    owner_d    = OWN_CPU;
                    mem_we_d   = cpu_we;
                    mem_addr_d = cpu_addr;
                    mem_din_d  = cpu_wdata;
                    mem_req_d  = 1'b1;
                    state_d    = ST_BUSY;
`ifdef ARB_FAIRNESS_EN
                    loss_d     = 3'd0;
`endif
                end
            end
            ST_BUSY: begin
                // Completion is credited to the latched owner even if its req has since dropped.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = ST_DONE;
                    case (owner_q)
                        OWN_DIO: dio_ack_d = 1'b1;
                        OWN_VID: begin
                            vid_ack_d  = 1'b1;
                            vid_data_d = mem_dout;
                        end
                        OWN_CPU: begin
                            cpu_ack_d = 1'b1;
                            if (!mem_we_q) begin
                                cpu_rdata_d = mem_dout;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge F14M or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_DIO;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            dio_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            vid_data_q  <= '0;
            cpu_rdata_q <= '0;
`ifdef ARB_FAIRNESS_EN
            loss_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            dio_ack_q   <= dio_ack_d;
            vid_ack_q   <= vid_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_data_q  <= vid_data_d;
            cpu_rdata_q <= cpu_rdata_d;
`ifdef ARB_FAIRNESS_EN
            loss_q      <= loss_d;
`endif
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign dio_ack    = dio_ack_q;
    assign vid_ack    = vid_ack_q;
    assign cpu_ack    = cpu_ack_q;
    assign vid_data   = vid_data_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_wait_n = !(cpu_req && !cpu_ack_q);

endmodule
